// File: rtl/time_set_buttons_pkg.sv
// Shared definitions for the time-set button conditioner.
//   - button index constants (bit positions in btn_in / btn_level / step_pulse)
//   - repeat FSM state encoding
//   - counter width helper
package time_set_buttons_pkg;

  localparam int NUM_BTN        = 4;
  localparam int BTN_MIN_ADD    = 0;
  localparam int BTN_MIN_MINUS  = 1;
  localparam int BTN_HOUR_ADD   = 2;
  localparam int BTN_HOUR_MINUS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Width that holds the largest of the three cycle counts without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-FF synchroniser, debounce counter and
// press/auto-repeat FSM.
//   i_clk    system clock
//   i_clr    synchronous active-high reset
//   i_btn    raw asynchronous button
//   o_level  debounced level
//   o_pulse  one-clk step pulse (first on press, then auto-repeat while held)
module btn_debounce
  import time_set_buttons_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam int TW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [TW-1:0] C_DEB = TW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] C_DLY = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] C_PER = TW'(REPEAT_PERIOD - 1);

  logic          r_sync1, r_sync2;
  logic          r_level;
  logic [TW-1:0] r_db_cnt;

  rpt_state_e    r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_raw,   w_raw_nxt;

  // Synchroniser + debounce: level flips only after the synchronised input
  // has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == C_DEB) begin
        r_level  <= ~r_level;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_raw   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_raw   <= w_raw_nxt;
    end
  end

  // IDLE is only ever entered with the level low, so a high level seen in
  // IDLE is always a fresh rising edge.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_raw_nxt   = 1'b0;
    if (!r_level) begin
      w_state_nxt = IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_raw_nxt   = 1'b1;
          w_timer_nxt = C_DLY;
          w_state_nxt = HOLD;
        end
        HOLD: begin
          if (r_timer == '0) begin
            w_raw_nxt   = 1'b1;
            w_timer_nxt = C_PER;
            w_state_nxt = REPEAT;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        REPEAT: begin
          if (r_timer == '0) begin
            w_raw_nxt   = 1'b1;
            w_timer_nxt = C_PER;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  assign o_level = r_level;
  // A pulse registered on the same edge the level falls is dropped, so no
  // pulse ever appears after release.
  assign o_pulse = r_raw & r_level;

endmodule

// File: rtl/time_set_buttons.sv
// Conditions the four time-set buttons for the minute/hour counters.
//   clk         system clock
//   clr         synchronous active-high reset
//   btn_in      raw buttons [0]min_add [1]min_minus [2]hour_add [3]hour_minus
//   btn_level   debounced levels
//   step_pulse  one-clk step pulses, same mapping; opposite buttons of one
//               field held together suppress that field's pulses
module time_set_buttons
  import time_set_buttons_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] step_pulse
);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_btn (
      .i_clk  (clk),
      .i_clr  (clr),
      .i_btn  (btn_in[i]),
      .o_level(w_level[i]),
      .o_pulse(w_raw[i])
    );
  end

  assign btn_level = w_level;

  // Masking only gates the outputs; both FSMs keep their schedules.
  assign step_pulse[BTN_MIN_ADD]    = w_raw[BTN_MIN_ADD]    & ~w_level[BTN_MIN_MINUS];
  assign step_pulse[BTN_MIN_MINUS]  = w_raw[BTN_MIN_MINUS]  & ~w_level[BTN_MIN_ADD];
  assign step_pulse[BTN_HOUR_ADD]   = w_raw[BTN_HOUR_ADD]   & ~w_level[BTN_HOUR_MINUS];
  assign step_pulse[BTN_HOUR_MINUS] = w_raw[BTN_HOUR_MINUS] & ~w_level[BTN_HOUR_ADD];

endmodule

// File: tb/tb_time_set_buttons.sv
module tb_time_set_buttons;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = 2 + DB + 1;   // input change -> level change, in cycles

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] step_pulse;

  always #5 clk = ~clk;

  time_set_buttons #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .step_pulse(step_pulse)
  );

  typedef struct {
    string      tag;
    int         k;
    bit         clr;
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] pls;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   nvec  = 0;
  int   nfail = 0;

  function automatic bit in_iv(input int k, input int s, input int e);
    return (k >= s) && (k < e);
  endfunction

  // First pulse at p, then p+RD, then every RP.
  function automatic bit on_sched(input int k, input int p);
    return (k == p) || ((k >= p + RD) && (((k - p - RD) % RP) == 0));
  endfunction

  task automatic add(input string tag, input int k, input bit c,
                     input logic [3:0] b, input logic [3:0] l, input logic [3:0] p);
    vec_t v;
    v.tag = tag; v.k = k; v.clr = c; v.btn = b; v.lvl = l; v.pls = p;
    tbl.push_back(v);
  endtask

  // Scoreboard: expectation for cycle k is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      nvec++;
      if (btn_level !== e.lvl || step_pulse !== e.pls) begin
        nfail++;
        $display("FAIL %s[%0d]: btn_level=%b step_pulse=%b, expected btn_level=%b step_pulse=%b",
                 e.tag, e.k, btn_level, step_pulse, e.lvl, e.pls);
      end
    end
  end

  initial begin
    clr    = 1'b1;
    btn_in = 4'hF;

    // reset with all buttons pressed
    for (int k = 0; k < 3; k++) add("reset", k, 1'b1, 4'hF, 4'h0, 4'h0);
    for (int k = 0; k < 6; k++) add("idle", k, 1'b0, 4'h0, 4'h0, 4'h0);

    // clean press of [0], held 10 clk
    for (int k = 0; k < 25; k++) begin
      logic b, l, p;
      b = (k < 10);
      l = in_iv(k, LAT, 10 + LAT);
      p = l && on_sched(k, LAT + 1);
      add("press", k, 1'b0, {3'b0, b}, {3'b0, l}, {3'b0, p});
    end

    // bounce on [2]: toggles every 2 clk, never settles long enough
    for (int k = 0; k < 30; k++) begin
      logic b;
      b = (k < 20) && (((k / 2) % 2) == 0);
      add("bounce", k, 1'b0, {1'b0, b, 2'b0}, 4'h0, 4'h0);
    end

    // auto-repeat on [3], held 60 clk
    for (int k = 0; k < 80; k++) begin
      logic b, l, p;
      b = (k < 60);
      l = in_iv(k, LAT, 60 + LAT);
      p = l && on_sched(k, LAT + 1);
      add("repeat", k, 1'b0, {b, 3'b0}, {l, 3'b0}, {p, 3'b0});
    end

    // conflict: [0] and [1] together; [1] released at 40, [0] at 70
    for (int k = 0; k < 90; k++) begin
      logic b0, b1, l0, l1, p0, p1;
      b0 = (k < 70);
      b1 = (k < 40);
      l0 = in_iv(k, LAT, 70 + LAT);
      l1 = in_iv(k, LAT, 40 + LAT);
      p0 = l0 && !l1 && on_sched(k, LAT + 1);
      p1 = l1 && !l0 && on_sched(k, LAT + 1);
      add("conflict", k, 1'b0, {2'b0, b1, b0}, {2'b0, l1, l0}, {2'b0, p1, p0});
    end

    // clr for one clk while [2] is in REPEAT; reset takes effect at edge 41,
    // after which the held button is re-synchronised and re-debounced
    for (int k = 0; k < 95; k++) begin
      logic c, b, l, p;
      c = (k == 40);
      b = (k < 75);
      l = in_iv(k, LAT, 41) || in_iv(k, 41 + LAT, 75 + LAT);
      p = l && ((k < 41) ? on_sched(k, LAT + 1) : on_sched(k, 41 + LAT + 1));
      add("clr_mid", k, c, {1'b0, b, 2'b0}, {1'b0, l, 2'b0}, {1'b0, p, 2'b0});
    end

    @(posedge clk);
    foreach (tbl[i]) begin
      #1;
      clr    = tbl[i].clr;
      btn_in = tbl[i].btn;
      sb.push_back(tbl[i]);
      @(posedge clk);
    end
    #1;
    clr    = 1'b0;
    btn_in = 4'h0;
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
